// File: rtl/pwm_peripheral_if.sv
// Write-port bundle between the SPI receive stage and the PWM register bank.
interface pwm_peripheral_if;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_err;

   modport master (output wr_valid, wr_addr, wr_data, input wr_err);
   modport slave  (input wr_valid, wr_addr, wr_data, output wr_err);
endinterface

// File: rtl/pwm_peripheral.sv
// Five-register control bank driving 16 pins as forced-low, forced-high or a
// shared PWM waveform whose duty is shadowed at each period boundary.
module pwm_peripheral #(
   parameter int unsigned CLK_DIV  = 13,
   parameter int unsigned MAX_ADDR = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pwm_peripheral_if.slave         wr_if,
   output logic [7:0]              out_lo,
   output logic [7:0]              out_hi,
   output logic                    period_start
);

   localparam logic [6:0] ADDR_LAST  = 7'(MAX_ADDR);
   localparam logic [7:0] PRESC_LAST = 8'(CLK_DIV - 1);

   logic [15:0] en_out_q, en_out_d;
   logic [15:0] en_pwm_q, en_pwm_d;
   logic [7:0]  duty_q, duty_d;
   logic [7:0]  duty_act_q, duty_act_d;
   logic [7:0]  presc_q, presc_d;
   logic [7:0]  pwm_cnt_q, pwm_cnt_d;
   logic [15:0] out_q, out_d;
   logic        wr_err_q, wr_err_d;
   logic        period_start_q, period_start_d;

   logic        tick;
   logic        boundary;
   logic        pwm_level;

   always_comb begin
      en_out_d = en_out_q;
      en_pwm_d = en_pwm_q;
      duty_d   = duty_q;
      wr_err_d = 1'b0;
      if (wr_if.wr_valid) begin
         if (wr_if.wr_addr > ADDR_LAST) begin
            wr_err_d = 1'b1;
         end else begin
            case (wr_if.wr_addr)
               7'd0:    en_out_d[7:0]  = wr_if.wr_data;
               7'd1:    en_out_d[15:8] = wr_if.wr_data;
               7'd2:    en_pwm_d[7:0]  = wr_if.wr_data;
               7'd3:    en_pwm_d[15:8] = wr_if.wr_data;
               7'd4:    duty_d         = wr_if.wr_data;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      tick     = (presc_q == PRESC_LAST);
      presc_d  = tick ? '0 : presc_q + 8'd1;
      pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      boundary = tick && (pwm_cnt_q == 8'hFF);
      // duty_q here is the pre-write value, so a write on the boundary edge waits a period
      duty_act_d = boundary ? duty_q : duty_act_q;
      pwm_level  = (duty_act_q == 8'hFF) || (pwm_cnt_q < duty_act_q);
      out_d      = en_out_q & (~en_pwm_q | {16{pwm_level}});
      period_start_d = boundary;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_out_q       <= '0;
         en_pwm_q       <= '0;
         duty_q         <= '0;
         duty_act_q     <= '0;
         presc_q        <= '0;
         pwm_cnt_q      <= '0;
         out_q          <= '0;
         wr_err_q       <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         en_out_q       <= en_out_d;
         en_pwm_q       <= en_pwm_d;
         duty_q         <= duty_d;
         duty_act_q     <= duty_act_d;
         presc_q        <= presc_d;
         pwm_cnt_q      <= pwm_cnt_d;
         out_q          <= out_d;
         wr_err_q       <= wr_err_d;
         period_start_q <= period_start_d;
      end
   end

   assign out_lo       = out_q[7:0];
   assign out_hi       = out_q[15:8];
   assign period_start = period_start_q;
   assign wr_if.wr_err = wr_err_q;

endmodule
